// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle 32-bit right shifter (srl / sra).
// One logarithmic stage (1, 2, 4, 8, 16) is applied per clock under a
// start/done handshake. Out is registered and only changes when a result
// completes or on reset.
module shift_right_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] S,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [2:0]       k_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [4:0]       shamt_q;
    logic             fill_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;

    // Only the low five bits of the shift amount matter; the rest is dropped.
    logic unused_s;
    assign unused_s = ^S[WIDTH-1:5];

    // Stage k: shift by 2^k with the captured fill bit when shamt[k] is set.
    always_comb begin
        work_d = work_q;
        if (shamt_q[k_q]) begin
            case (k_q)
                3'd0:    work_d = {{1{fill_q}},  work_q[WIDTH-1:1]};
                3'd1:    work_d = {{2{fill_q}},  work_q[WIDTH-1:2]};
                3'd2:    work_d = {{4{fill_q}},  work_q[WIDTH-1:4]};
                3'd3:    work_d = {{8{fill_q}},  work_q[WIDTH-1:8]};
                3'd4:    work_d = {{16{fill_q}}, work_q[WIDTH-1:16]};
                default: work_d = work_q;
            endcase
        end else begin
            work_d = work_q;
        end
    end

    // Control FSM: accept a request in IDLE, run five stages, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            work_q  <= {WIDTH{1'b0}};
            shamt_q <= 5'd0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        work_q  <= A;
                        shamt_q <= S[4:0];
                        // Sign fill is decided once, from the original operand.
                        fill_q  <= arith & A[WIDTH-1];
                        k_q     <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    if (k_q == 3'd4) begin
                        out_q   <= work_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        k_q     <= 3'd0;
                        state_q <= IDLE;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    k_q     <= 3'd0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Out  = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: table vectors, random operations
// against an arithmetic reference, and hand-written handshake corner cases.
module tb_shift_right_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] S;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] Out;

    int errors = 0;
    int checks = 0;

    shift_right_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .S     (S),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .Out   (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] s;
        logic        ar;
        logic [31:0] exp;
    } vec_t;

    // Reference: plain shift operators on the low five bits of S.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] s,
                                              input logic ar);
        int unsigned sh;
        sh = s & 32'd31;
        if (ar) return 32'($signed(a) >>> sh);
        else    return a >> sh;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap: got busy=%0b done=%0b expected not both", busy, done);
            end
        end
    end

    // Drive a request; returns #1 after the accepting edge with inputs scrambled.
    task automatic accept(input logic [31:0] a, input logic [31:0] s, input logic ar,
                          input bit now);
        if (!now) @(negedge clk);
        A = a; S = s; arith = ar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; S = $urandom; arith = 1'($urandom);
    endtask

    // Wait (bounded) for done; checks latency, busy length, held Out, result.
    task automatic wait_done(input string name, input logic [31:0] exp);
        int lat = 0;
        int bcnt = 0;
        bit held = 1'b1;
        logic [31:0] prev;
        prev = Out;
        while (!done && lat < 10) begin
            if (busy) bcnt++;
            if (Out !== prev) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd5);
        chk({name, "_busy_cycles"}, 32'(bcnt), 32'd5);
        chk({name, "_out_held"}, 32'(held), 32'd1);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_out"}, Out, exp);
    endtask

    vec_t vecs[$];

    initial begin
        int ndone;
        int first;
        logic [31:0] a, s;
        logic ar;

        vecs.push_back('{32'h80000000, 32'd31,       1'b0, 32'h00000001});
        vecs.push_back('{32'h80000000, 32'd4,        1'b1, 32'hF8000000});
        vecs.push_back('{32'h80000000, 32'd4,        1'b0, 32'h08000000});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000025, 1'b0, 32'h07FFFFFF});
        vecs.push_back('{32'h12345678, 32'd0,        1'b1, 32'h12345678});
        vecs.push_back('{32'hFFFFFFFF, 32'd31,       1'b1, 32'hFFFFFFFF});
        vecs.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000});
        vecs.push_back('{32'hA5A5A5A5, 32'd16,       1'b1, 32'hFFFFA5A5});

        rst_n = 1'b0; start = 1'b0; A = 32'd0; S = 32'd0; arith = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out", Out, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Idle with no start: nothing happens
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            accept(vecs[i].a, vecs[i].s, vecs[i].ar, 1'b0);
            chk($sformatf("vec%0d_busy_on", i), 32'(busy), 32'd1);
            wait_done($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            a = $urandom; s = $urandom; ar = 1'($urandom);
            if (i % 4 == 0) a[31] = 1'b1;
            accept(a, s, ar, 1'b0);
            wait_done($sformatf("rnd%0d", i), ref_shift(a, s, ar));
        end

        // Start while busy: second request at the 2nd busy cycle is ignored
        accept(32'h80000000, 32'd31, 1'b0, 1'b0);
        ndone = 0; first = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) begin A = 32'hFFFFFFFF; S = 32'd0; arith = 1'b1; start = 1'b1; end
            if (c == 2) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin ndone++; if (first == 0) first = c; end
            if (c == 5) chk("busy_ign_busy_drop", 32'(busy), 32'd0);
            if (c == 5) chk("busy_ign_out", Out, 32'h00000001);
        end
        chk("busy_ign_done_count", 32'(ndone), 32'd1);
        chk("busy_ign_done_edge", 32'(first), 32'd5);

        // Back-to-back: start during the done cycle is accepted
        accept(32'h80000000, 32'd4, 1'b1, 1'b0);
        wait_done("b2b_first", 32'hF8000000);
        accept(32'h00000F00, 32'd8, 1'b0, 1'b1);
        chk("b2b_busy_on", 32'(busy), 32'd1);
        chk("b2b_out_kept", Out, 32'hF8000000);
        wait_done("b2b_second", 32'h0000000F);

        // Asynchronous reset mid-operation
        accept(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0; start = 1'b1; A = 32'h12345678; S = 32'd0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_out", Out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1; start = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("rst_no_activity", 32'(ndone), 32'd0);
        accept(32'h80000000, 32'd31, 1'b1, 1'b0);
        wait_done("rst_after", 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
